// File: rtl/vx_gfx_mem_arb.sv
// Round-robin merge of the cluster graphics cache memory ports onto one L2 port.
// Requests pass through a 2-entry buffer; responses are routed back by the tag select LSBs.
module vx_gfx_mem_arb #(
  parameter int unsigned NUM_INPUTS     = 3,
  parameter int unsigned ADDR_WIDTH     = 26,
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned TAG_IN_WIDTH   = 8,
  localparam int unsigned SEL_WIDTH     = $clog2(NUM_INPUTS),
  localparam int unsigned TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_WIDTH,
  localparam int unsigned BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_INPUTS-1:0]              in_req_valid,
  input  logic [NUM_INPUTS-1:0]              in_req_rw,
  input  logic [NUM_INPUTS*ADDR_WIDTH-1:0]   in_req_addr,
  input  logic [NUM_INPUTS*BE_WIDTH-1:0]     in_req_byteen,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_req_data,
  input  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0] in_req_tag,
  output logic [NUM_INPUTS-1:0]              in_req_ready,
  output logic                               out_req_valid,
  output logic                               out_req_rw,
  output logic [ADDR_WIDTH-1:0]              out_req_addr,
  output logic [BE_WIDTH-1:0]                out_req_byteen,
  output logic [DATA_WIDTH-1:0]              out_req_data,
  output logic [TAG_OUT_WIDTH-1:0]           out_req_tag,
  input  logic                               out_req_ready,
  input  logic                               out_rsp_valid,
  input  logic [DATA_WIDTH-1:0]              out_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]           out_rsp_tag,
  output logic                               out_rsp_ready,
  output logic [NUM_INPUTS-1:0]              in_rsp_valid,
  output logic [DATA_WIDTH-1:0]              in_rsp_data,
  output logic [TAG_IN_WIDTH-1:0]            in_rsp_tag,
  input  logic [NUM_INPUTS-1:0]              in_rsp_ready
);

  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic                     rw;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [BE_WIDTH-1:0]      byteen;
    logic [DATA_WIDTH-1:0]    data;
    logic [TAG_OUT_WIDTH-1:0] tag;
  } req_t;

  logic [SEL_WIDTH-1:0]  ptr;
  logic [NUM_INPUTS-1:0] grant_c;
  logic [SEL_WIDTH-1:0]  gsel_c;
  logic                  found_c;
  req_t                  enq_data_c;
  req_t                  head_c;
  req_t                  buf_q [DEPTH];
  logic                  rd_idx;
  logic                  wr_idx;
  logic [1:0]            count;
  logic                  buf_full_c;
  logic                  enq_c;
  logic                  deq_c;
  logic [SEL_WIDTH-1:0]  rsp_sel_c;
  logic                  rsp_bad_c;

  // First valid input at or after ptr: scan [ptr, N-1] then wrap to [0, ptr-1].
  always_comb begin
    grant_c = '0;
    gsel_c  = '0;
    found_c = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!found_c && in_req_valid[i] && (SEL_WIDTH'(i) >= ptr)) begin
        grant_c[i] = 1'b1;
        gsel_c     = SEL_WIDTH'(i);
        found_c    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!found_c && in_req_valid[i]) begin
        grant_c[i] = 1'b1;
        gsel_c     = SEL_WIDTH'(i);
        found_c    = 1'b1;
      end
    end
  end

  always_comb begin
    enq_data_c = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_c[i]) begin
        enq_data_c.rw     = in_req_rw[i];
        enq_data_c.addr   = in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        enq_data_c.byteen = in_req_byteen[i*BE_WIDTH +: BE_WIDTH];
        enq_data_c.data   = in_req_data[i*DATA_WIDTH +: DATA_WIDTH];
        enq_data_c.tag    = {in_req_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH], SEL_WIDTH'(i)};
      end
    end
  end

  // A full buffer refuses enqueue even when it is draining this cycle.
  assign buf_full_c   = (count == 2'd2);
  assign in_req_ready = grant_c & {NUM_INPUTS{!buf_full_c && !reset}};
  assign enq_c        = |in_req_ready;
  assign deq_c        = out_req_valid && out_req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr    <= '0;
      rd_idx <= 1'b0;
      wr_idx <= 1'b0;
      count  <= '0;
    end else begin
      if (enq_c) begin
        ptr    <= (gsel_c == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0 : gsel_c + SEL_WIDTH'(1);
        wr_idx <= ~wr_idx;
      end
      if (deq_c) begin
        rd_idx <= ~rd_idx;
      end
      count <= count + 2'(enq_c) - 2'(deq_c);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_c) begin
      buf_q[wr_idx] <= enq_data_c;
    end
  end

  assign head_c         = buf_q[rd_idx];
  assign out_req_valid  = (count != 2'd0);
  assign out_req_rw     = head_c.rw;
  assign out_req_addr   = head_c.addr;
  assign out_req_byteen = head_c.byteen;
  assign out_req_data   = head_c.data;
  assign out_req_tag    = head_c.tag;

  // Response demux; an unmapped select is consumed and dropped.
  assign rsp_sel_c   = out_rsp_tag[SEL_WIDTH-1:0];
  assign rsp_bad_c   = (32'(rsp_sel_c) >= NUM_INPUTS);
  assign in_rsp_data = out_rsp_data;
  assign in_rsp_tag  = out_rsp_tag[TAG_OUT_WIDTH-1:SEL_WIDTH];

  always_comb begin
    in_rsp_valid  = '0;
    out_rsp_ready = rsp_bad_c;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (rsp_sel_c == SEL_WIDTH'(i)) begin
        in_rsp_valid[i] = out_rsp_valid;
        out_rsp_ready   = in_rsp_ready[i];
      end
    end
  end

  unmapped_rsp_sel: assert property (@(posedge clk) disable iff (reset) !(out_rsp_valid && rsp_bad_c))
    else $warning("vx_gfx_mem_arb: response with unmapped sel %0d dropped", rsp_sel_c);

endmodule

// File: tb/tb_vx_gfx_mem_arb.sv
// Bench for vx_gfx_mem_arb: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vx_gfx_mem_arb;
  localparam int unsigned N   = 3;
  localparam int unsigned AW  = 26;
  localparam int unsigned DW  = 512;
  localparam int unsigned BW  = DW / 8;
  localparam int unsigned TW  = 8;
  localparam int unsigned SW  = 2;
  localparam int unsigned TOW = TW + SW;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_req_valid, in_req_rw, in_req_ready;
  logic [N*AW-1:0] in_req_addr;
  logic [N*BW-1:0] in_req_byteen;
  logic [N*DW-1:0] in_req_data;
  logic [N*TW-1:0] in_req_tag;
  logic            out_req_valid, out_req_rw, out_req_ready;
  logic [AW-1:0]   out_req_addr;
  logic [BW-1:0]   out_req_byteen;
  logic [DW-1:0]   out_req_data;
  logic [TOW-1:0]  out_req_tag;
  logic            out_rsp_valid, out_rsp_ready;
  logic [DW-1:0]   out_rsp_data;
  logic [TOW-1:0]  out_rsp_tag;
  logic [N-1:0]    in_rsp_valid, in_rsp_ready;
  logic [DW-1:0]   in_rsp_data;
  logic [TW-1:0]   in_rsp_tag;

  vx_gfx_mem_arb dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_addr(in_req_addr),
    .in_req_byteen(in_req_byteen), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready),
    .out_req_valid(out_req_valid), .out_req_rw(out_req_rw), .out_req_addr(out_req_addr),
    .out_req_byteen(out_req_byteen), .out_req_data(out_req_data), .out_req_tag(out_req_tag),
    .out_req_ready(out_req_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data), .out_rsp_tag(out_rsp_tag),
    .out_rsp_ready(out_rsp_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
    .in_rsp_ready(in_rsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           rw;
    logic [AW-1:0]  addr;
    logic [BW-1:0]  be;
    logic [DW-1:0]  data;
    logic [TOW-1:0] tag;
  } exp_t;

  exp_t        mq[$];
  int unsigned mptr;
  int          acc_log[$];

  logic [N-1:0]  pv;
  logic          p_rw   [N];
  logic [AW-1:0] p_addr [N];
  logic [BW-1:0] p_be   [N];
  logic [DW-1:0] p_data [N];
  logic [TW-1:0] p_tag  [N];
  logic [N-1:0]  acc;
  logic          rsp_acc;
  int            req_pct;
  int            rdy_mode;
  bit            rsp_rand;
  int            checks;
  int            failures;
  int            n0;
  logic [DW-1:0] dval;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < int'(DW / 32); k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic apply();
    for (int i = 0; i < int'(N); i++) begin
      in_req_valid[i]           = pv[i];
      in_req_rw[i]              = p_rw[i];
      in_req_addr[i*AW +: AW]   = p_addr[i];
      in_req_byteen[i*BW +: BW] = p_be[i];
      in_req_data[i*DW +: DW]   = p_data[i];
      in_req_tag[i*TW +: TW]    = p_tag[i];
    end
  endtask

  // One driver step just after the rising edge: retire accepted items, then refill.
  task automatic cyc();
    @(posedge clk);
    #1;
    pv = pv & ~acc;
    if (rsp_acc) out_rsp_valid = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!pv[i] && (int'($urandom_range(99)) < req_pct)) begin
        pv[i]     = 1'b1;
        p_rw[i]   = 1'($urandom_range(1));
        p_addr[i] = AW'($urandom);
        p_be[i]   = {$urandom, $urandom};
        p_data[i] = rnd_data();
        p_tag[i]  = TW'($urandom);
      end
    end
    case (rdy_mode)
      0:       out_req_ready = 1'($urandom_range(1));
      1:       out_req_ready = 1'b1;
      default: out_req_ready = 1'b0;
    endcase
    if (rsp_rand) begin
      if (!out_rsp_valid) begin
        out_rsp_valid = 1'($urandom_range(1));
        out_rsp_tag   = {TW'($urandom), SW'($urandom_range(2))};
        out_rsp_data  = rnd_data();
      end
      in_rsp_ready = N'($urandom);
    end
    apply();
  endtask

  // Reference model: predicts this cycle's outputs and the transfers at the next rising edge.
  always @(negedge clk) begin
    logic [N-1:0] er;
    logic [N-1:0] erv;
    logic         err;
    int           g;
    int           s;
    if (reset) begin
      mq.delete();
      mptr    = 0;
      acc     = '0;
      rsp_acc = 1'b0;
      chk("rst_out_req_valid", DW'(out_req_valid), DW'(1'b0));
      chk("rst_in_req_ready", DW'(in_req_ready), DW'(3'b000));
    end else begin
      er = '0;
      g  = -1;
      if (mq.size() < 2) begin
        for (int k = 0; k < int'(N); k++) begin
          int i;
          i = int'((mptr + k) % N);
          if (g < 0 && in_req_valid[i]) begin
            g     = i;
            er[i] = 1'b1;
          end
        end
      end
      chk("in_req_ready", DW'(in_req_ready), DW'(er));
      chk("out_req_valid", DW'(out_req_valid), DW'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("out_req_rw", DW'(out_req_rw), DW'(mq[0].rw));
        chk("out_req_addr", DW'(out_req_addr), DW'(mq[0].addr));
        chk("out_req_byteen", DW'(out_req_byteen), DW'(mq[0].be));
        chk("out_req_data", out_req_data, mq[0].data);
        chk("out_req_tag", DW'(out_req_tag), DW'(mq[0].tag));
      end
      s   = int'(out_rsp_tag[SW-1:0]);
      erv = '0;
      err = 1'b1;
      for (int i = 0; i < int'(N); i++) begin
        if (s == i) begin
          erv[i] = out_rsp_valid;
          err    = in_rsp_ready[i];
        end
      end
      chk("in_rsp_valid", DW'(in_rsp_valid), DW'(erv));
      chk("out_rsp_ready", DW'(out_rsp_ready), DW'(err));
      chk("in_rsp_tag", DW'(in_rsp_tag), DW'(out_rsp_tag >> SW));
      chk("in_rsp_data", in_rsp_data, out_rsp_data);
      if (mq.size() != 0 && out_req_ready) void'(mq.pop_front());
      if (g >= 0) begin
        mq.push_back('{rw: p_rw[g], addr: p_addr[g], be: p_be[g], data: p_data[g],
                       tag: {p_tag[g], SW'(g)}});
        mptr = (g + 1) % N;
        acc_log.push_back(g);
      end
      acc     = er;
      rsp_acc = out_rsp_valid && err;
    end
  end

  initial begin
    checks = 0; failures = 0;
    pv = '0; acc = '0; rsp_acc = 1'b0;
    req_pct = 0; rdy_mode = 1; rsp_rand = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      p_rw[i] = 1'b0; p_addr[i] = '0; p_be[i] = '0; p_data[i] = '0; p_tag[i] = '0;
    end
    out_req_ready = 1'b1; out_rsp_valid = 1'b0; out_rsp_tag = '0; out_rsp_data = '0;
    in_rsp_ready = '0;
    apply();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Single read from input 1 and its response.
    cyc();
    pv[1] = 1'b1; p_rw[1] = 1'b0; p_addr[1] = 26'h100; p_tag[1] = 8'h05;
    p_be[1] = '0; p_data[1] = rnd_data();
    apply();
    @(negedge clk);
    chk("t1_grant", DW'(in_req_ready), DW'(3'b010));
    cyc();
    @(negedge clk);
    chk("t1_out_valid", DW'(out_req_valid), DW'(1'b1));
    chk("t1_out_addr", DW'(out_req_addr), DW'(26'h100));
    chk("t1_out_tag", DW'(out_req_tag), DW'(10'h015));
    chk("t1_out_rw", DW'(out_req_rw), DW'(1'b0));
    cyc();
    dval = rnd_data();
    out_rsp_valid = 1'b1; out_rsp_tag = 10'h015; out_rsp_data = dval; in_rsp_ready = 3'b111;
    #1;
    chk("t1_rsp_valid", DW'(in_rsp_valid), DW'(3'b010));
    chk("t1_rsp_tag", DW'(in_rsp_tag), DW'(8'h05));
    chk("t1_rsp_data", in_rsp_data, dval);

    // Response to input 2 held while it is not ready.
    cyc();
    out_rsp_valid = 1'b1; out_rsp_tag = {8'h3c, 2'd2}; out_rsp_data = rnd_data();
    in_rsp_ready = 3'b011;
    #1;
    chk("t4_hold_ready", DW'(out_rsp_ready), DW'(1'b0));
    chk("t4_hold_valid", DW'(in_rsp_valid), DW'(3'b100));
    cyc();
    chk("t4_still_held", DW'(out_rsp_ready), DW'(1'b0));
    in_rsp_ready = 3'b100;
    #1;
    chk("t4_release_ready", DW'(out_rsp_ready), DW'(1'b1));
    cyc();

    // Write from input 2, then a response with an unmapped select.
    pv[2] = 1'b1; p_rw[2] = 1'b1; p_be[2] = '1; p_data[2] = {64{8'hA5}};
    p_addr[2] = 26'h2a5a5a5; p_tag[2] = 8'h77;
    apply();
    cyc();
    @(negedge clk);
    chk("t6_out_rw", DW'(out_req_rw), DW'(1'b1));
    chk("t6_out_byteen", DW'(out_req_byteen), DW'({64{1'b1}}));
    chk("t6_out_data", out_req_data, {64{8'hA5}});
    chk("t6_out_tag", DW'(out_req_tag), DW'({8'h77, 2'd2}));
    cyc();
    out_rsp_valid = 1'b1; out_rsp_tag = {8'h11, 2'd3}; in_rsp_ready = '0;
    #1;
    chk("t6_drop_ready", DW'(out_rsp_ready), DW'(1'b1));
    chk("t6_drop_valid", DW'(in_rsp_valid), DW'(3'b000));
    cyc();

    // Fill the buffer, then reset asynchronously between edges.
    req_pct = 100; rdy_mode = 2;
    repeat (4) cyc();
    @(negedge clk);
    chk("t5_pre_valid", DW'(out_req_valid), DW'(1'b1));
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("t5_async_valid", DW'(out_req_valid), DW'(1'b0));
    chk("t5_async_ready", DW'(in_req_ready), DW'(3'b000));
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    rdy_mode = 1; out_req_ready = 1'b1;
    acc_log.delete();
    @(negedge clk);
    chk("t5_first_grant", DW'(in_req_ready), DW'(3'b001));

    // All inputs continuously valid: strict rotation, one per cycle.
    repeat (6) cyc();
    chk("t2_count", DW'(acc_log.size()), DW'(6));
    if (acc_log.size() >= 6) begin
      for (int k = 0; k < 6; k++) chk("t2_order", DW'(acc_log[k]), DW'(k % 3));
    end

    // Backpressure: exactly two requests absorbed, then the inputs stall.
    req_pct = 0;
    repeat (6) cyc();
    req_pct = 100; rdy_mode = 2;
    n0 = acc_log.size();
    repeat (5) cyc();
    chk("t3_buffered", DW'(acc_log.size() - n0), DW'(2));
    #1;
    chk("t3_stalled", DW'(in_req_ready), DW'(3'b000));
    rdy_mode = 1; req_pct = 0;
    repeat (8) cyc();

    // Randomized traffic on both paths.
    req_pct = 40; rdy_mode = 0; rsp_rand = 1'b1;
    repeat (3000) cyc();
    rsp_rand = 1'b0; req_pct = 0; rdy_mode = 1;
    repeat (8) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
